lcb_frame_collector: RTL
========================

LCB_FRAME_COLLECTOR -- requirements
Module: lcb_frame_collector

Interface
REQ-001 Parameter: BYTES, 5'd16, frame length in bytes, checksum byte included; legal range 2..31.
REQ-002 Parameter: TIMEOUT, 16'd1000, maximum inter-byte gap in clk cycles before the frame is aborted.
REQ-003 Port: clk  input  1  system clock (clk80MHz domain); the only clock.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: strob  input  1  one-cycle byte-valid pulse from UART_RX oValid.
REQ-006 Port: iData  input  8  received byte; valid when strob=1.
REQ-007 Port: wrAdr  output  5  ramUART write address.
REQ-008 Port: oData  output  8  ramUART write data.
REQ-009 Port: WE  output  1  ramUART write enable, one-cycle pulse per byte.
REQ-010 Port: full  output  1  one-cycle pulse: complete frame with good checksum is in RAM.
REQ-011 Port: err  output  1  one-cycle pulse: frame aborted (bad checksum or timeout).
REQ-012 Port: errCnt  output  8  saturating count of err pulses since reset.

Function
REQ-013 States SHALL be IDLE, RECV, CHECK; reset state IDLE.
REQ-014 IDLE: strob SHALL capture byte 0 -> RECV, byte index 1, sum = iData, gap counter 0.
REQ-015 RECV: each strob SHALL store the byte at the current index and increment the index; for indices 0..BYTES-2 it SHALL add iData to the 8-bit sum (mod 256, carry discarded).
REQ-016 The strob carrying index BYTES-1 (checksum byte) SHALL -> CHECK, comparing iData against the sum.
REQ-017 Every accepted byte SHALL give WE=1 exactly one cycle after its strob, with wrAdr=index and oData=byte registered in the same cycle.
REQ-018 CHECK lasts one cycle (two cycles after last strob): full=1 if checksum matched, else err=1; then -> IDLE.
REQ-019 A strob arriving during CHECK SHALL be accepted as byte 0 of the next frame (as REQ-014) -> RECV; the result pulse of the previous frame still fires.
REQ-020 RECV: gap counter SHALL increment each cycle without strob and clear on strob; on reaching TIMEOUT it SHALL pulse err and -> IDLE; bytes already written stay in RAM, no full pulse.
REQ-021 Strob and timeout in the same cycle: strob SHALL win; no err.
REQ-022 errCnt SHALL increment on each err pulse and saturate at 8'hFF.
REQ-023 full and err SHALL never be 1 in the same cycle.
REQ-024 Every new frame SHALL start at wrAdr 0; wrAdr never exceeds BYTES-1.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, index 0, sum 0, gap counter 0, wrAdr 0, oData 0, WE 0, full 0, err 0, errCnt 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no full or err pulse; next strob after reset release is byte 0.

Structure
REQ-027 Shared package lcb_rx_pkg SHALL hold the state encoding plus the BYTES and TIMEOUT defaults.
REQ-028 The gap counter SHALL be one sub-module, lcb_gap_timer (inputs clk, rst, run, clear; output expired); all other logic stays in lcb_frame_collector.

Verification (BYTES=4, TIMEOUT=200, strobs 160 cycles apart unless stated)
REQ-029 Bytes 01,02,03,06 -> WE at wrAdr 0,1,2,3 with those data; one full pulse 2 cycles after the 4th strob; err stays 0.
REQ-030 Bytes 01,02,03,07 -> four writes, err pulse 2 cycles after the 4th strob, no full, errCnt=1.
REQ-031 Bytes FF,FF,01,FF (sum wrap) -> full pulse; then bytes AA,BB followed by 200 idle cycles -> err, errCnt=1; next strob writes wrAdr 0.
REQ-032 Reset asserted after 2 bytes -> all outputs 0, no full/err; then 01,01,01,03 -> full.
REQ-033 Strob of a new frame exactly in the CHECK cycle -> previous full pulse still fires, new byte written at wrAdr 0 the next cycle; strob coinciding with timeout expiry -> no err.
REQ-034 260 consecutive bad-checksum frames -> errCnt stops at FF.

Source files
------------

// File: rtl/lcb_rx_pkg.sv
// Purpose : shared definitions for the LCB frame receiver (FSM encoding, default sizes).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: state_t (IDLE/RECV/CHECK), BYTES_DEF (frame length incl. checksum),
//           TIMEOUT_DEF (max inter-byte gap in clk cycles).
package lcb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [4:0]  BYTES_DEF   = 5'd16;
  localparam logic [15:0] TIMEOUT_DEF = 16'd1000;

endpackage

// File: rtl/lcb_gap_timer.sv
// Purpose : counts idle cycles between received bytes; flags when the gap reaches TIMEOUT.
// Latency : expired is combinational, high in the TIMEOUT-th consecutive idle cycle.
// Backpr. : none; clear (a byte arriving) always wins over expiry.
// Ports   : clk, rst (sync, active-high), run (frame in progress),
//           clear (byte strobe this cycle), expired (gap limit reached this cycle).
module lcb_gap_timer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  logic [15:0] gapCnt;

  // gapCnt holds the number of idle cycles already completed; the current idle
  // cycle is the TIMEOUT-th one when gapCnt == TIMEOUT-1.
  assign expired = run && !clear && (gapCnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      gapCnt <= 16'd0;
    end else if (!expired) begin
      gapCnt <= gapCnt + 16'd1;
    end
  end

endmodule

// File: rtl/lcb_frame_collector.sv
// Purpose : assembles UART bytes into a BYTES-long frame in ramUART, verifies the
//           trailing 8-bit additive checksum, aborts on an over-long inter-byte gap.
// Latency : WE 1 cycle after each strob; full/err 2 cycles after the checksum strob.
// Backpr. : none; every strob is accepted in every state.
// Ports   : clk, rst (sync, active-high), strob/iData (byte in), wrAdr/oData/WE (RAM
//           write), full (good frame pulse), err (abort pulse), errCnt (saturating).
module lcb_frame_collector
  import lcb_rx_pkg::*;
#(
  parameter logic [4:0]  BYTES   = BYTES_DEF,
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strob,
  input  logic [7:0] iData,
  output logic [4:0] wrAdr,
  output logic [7:0] oData,
  output logic       WE,
  output logic       full,
  output logic       err,
  output logic [7:0] errCnt
);

  state_t      state;
  state_t      stateNext;
  logic [4:0]  idx;
  logic [7:0]  sum;
  logic        match;
  logic        expired;
  logic        lastByte;
  logic        timeoutHit;
  logic        fullNext;
  logic        errNext;

  lcb_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) uGapTimer (
    .clk     (clk),
    .rst     (rst),
    .run     (state == RECV),
    .clear   (strob),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    lastByte   = 1'b0;
    timeoutHit = 1'b0;
    fullNext   = 1'b0;
    errNext    = 1'b0;
    case (state)
      IDLE: begin
        if (strob) stateNext = RECV;
      end
      RECV: begin
        lastByte   = strob && (idx == BYTES - 5'd1);
        timeoutHit = expired;
        if (lastByte)        stateNext = CHECK;
        else if (timeoutHit) stateNext = IDLE;
        errNext    = timeoutHit;
      end
      CHECK: begin
        // A strob here is byte 0 of the next frame; the verdict still goes out.
        stateNext = strob ? RECV : IDLE;
        fullNext  = match;
        errNext   = !match;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 5'd0;
      sum    <= 8'd0;
      match  <= 1'b0;
      wrAdr  <= 5'd0;
      oData  <= 8'd0;
      WE     <= 1'b0;
      full   <= 1'b0;
      err    <= 1'b0;
      errCnt <= 8'd0;
    end else begin
      WE   <= strob;
      full <= fullNext;
      err  <= errNext;
      if (errNext && (errCnt != 8'hFF)) errCnt <= errCnt + 8'd1;

      if (strob) begin
        oData <= iData;
        wrAdr <= (state == RECV) ? idx : 5'd0;
      end

      if (strob && (state != RECV)) begin
        // Byte 0 of a new frame: seed the running sum.
        idx <= 5'd1;
        sum <= iData;
      end else if (lastByte) begin
        match <= (iData == sum);
        idx   <= 5'd0;
      end else if (strob) begin
        sum <= sum + iData;
        idx <= idx + 5'd1;
      end else if (timeoutHit) begin
        idx <= 5'd0;
      end
    end
  end

endmodule
